bitstream_loss_head: RTL
========================

// Module: bitstream_loss_head
// PURPOSE
//  Output/loss stage directly downstream of a 3-to-1 unit. Drives fd_prop for a fixed window and
//  counts ones on the unit's forward output bitstream, then compares the count to a target.
//  Drives the resulting error back into the unit's backward input: bk_prop high, bout = direction.
//  One training step per start pulse; the top-level sequencer issues start and waits for done.
// PARAMETERS
//  WINDOW    256                  forward samples per step (>=2)
//  CNT_W     $clog2(WINDOW+1)     width of count/target
//  DEADBAND  2                    |error| at or below this is treated as 0 (only with macro)
// PORTS
//  clk_in      in   1        system clock
//  rst_in      in   1        synchronous reset, active-low
//  start_in    in   1        begin a step; sampled only in IDLE
//  target_in   in   CNT_W    desired ones-count; latched on accepted start
//  fin         in   1        forward bitstream from upstream unit (its fout)
//  fd_prop     out  1        forward-propagate enable to upstream unit
//  bk_prop     out  1        backward-propagate enable to upstream unit
//  bout        out  1        backward bit to upstream unit (its bin): 1 = raise, 0 = lower
//  count_out   out  CNT_W    ones counted in last completed window
//  error_out   out  CNT_W+1  signed target-count of last step (post-deadband)
//  busy_out    out  1        high in any state except IDLE
//  done_out    out  1        one-cycle pulse at step end
// BEHAVIOUR
//  Reset (rst_in==0 at posedge): state IDLE; all outputs, counters and latched target = 0.
//  Reset mid-step aborts immediately; no done pulse; fd_prop/bk_prop low the next cycle.
//  FSM: IDLE -> FWD -> CMP -> (BWD ->) DONE -> IDLE.
//   IDLE: start_in=1 latches target = min(target_in, WINDOW), clears ones counter -> FWD.
//   FWD: fd_prop=1 for exactly WINDOW cycles; fin sampled every cycle, ones counter += fin.
//     Counter never exceeds WINDOW, so no wrap. The last-sample cycle -> CMP.
//   CMP (1 cycle): count_out <= ones; err = target - ones in CNT_W+1 signed; error_out <= err.
//     err==0 -> DONE, else -> BWD with mag = |err|.
//   BWD: bk_prop=1, bout = (err>0) held constant, for exactly mag cycles -> DONE.
//   DONE (1 cycle): done_out=1, busy_out still 1 -> IDLE.
//  Outside FWD: fd_prop=0. Outside BWD: bk_prop=0, bout=0. fd_prop and bk_prop never both 1.
//  Timing: start accepted at edge N -> fd_prop high cycles N+1..N+WINDOW.
//    CMP at N+WINDOW+1; BWD from N+WINDOW+2 for mag cycles.
//    done_out at N+WINDOW+2+mag, or N+WINDOW+2 if err==0.
//  start_in while busy is ignored, not queued. start_in in the DONE cycle is also ignored.
//    Earliest restart is the first IDLE cycle.
//  count_out/error_out hold until the next CMP; not cleared by start.
//  target_in > WINDOW is clamped to WINDOW; target 0 with all-zero fin gives err 0, no BWD.
// CONFIGURATION
//  BITSTREAM_LOSS_DEADBAND_EN defined: in CMP, |err|<=DEADBAND forces err=0.
//    error_out reports 0, BWD is skipped, done at N+WINDOW+2.
//  BITSTREAM_LOSS_DEADBAND_EN undefined: DEADBAND unused; every nonzero err enters BWD.
// TESTING (WINDOW=16, DEADBAND=2)
//  1 Reset: hold rst_in=0 3 cycles with start_in=1 -> all outputs 0, busy_out 0.
//  2 Target 10, fin all-ones: fd_prop 16 cycles; count_out=16, error_out=-6.
//    bk_prop 6 cycles with bout=0; done 24 cycles after start.
//  3 Target 8, fin alternating 1010..: count 8, err 0, no bk_prop; done_out exactly 18 cycles after start.
//  4 Target 20 (clamped to 16), fin all-zero: error_out=+16, bk_prop 16 cycles bout=1.
//    start_in pulsed mid-FWD and in DONE is ignored.
//  5 Reset asserted 5 cycles into BWD: next cycle fd_prop=bk_prop=0, busy 0, no done pulse.
//    A fresh step then runs normally.
//  6 Target 9, fin count 8: with BITSTREAM_LOSS_DEADBAND_EN, error_out=0 and no BWD.
//    Without it, error_out=+1 and one bk_prop cycle with bout=1.

Source files
------------

// File: rtl/bitstream_loss_head.sv
// Loss stage for a bitstream unit: counts forward ones over a window, then drives |target-count| backward pulses.
// Optional deadband on the error is enabled by defining BITSTREAM_LOSS_DEADBAND_EN.
module bitstream_loss_head #(
  parameter int unsigned WINDOW   = 256,
  parameter int unsigned CNT_W    = $clog2(WINDOW + 1),
  parameter int unsigned DEADBAND = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [CNT_W-1:0] target_in,
  input  logic             fin,
  output logic             fd_prop,
  output logic             bk_prop,
  output logic             bout,
  output logic [CNT_W-1:0] count_out,
  output logic [CNT_W:0]   error_out,
  output logic             busy_out,
  output logic             done_out
);

  typedef enum logic [2:0] {IDLE, FWD, CMP, BWD, DONE} state_t;

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] DB  = CNT_W'(DEADBAND);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
`ifdef BITSTREAM_LOSS_DEADBAND_EN
  localparam logic DB_EN = 1'b1;
`else
  localparam logic DB_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] target_q, ones_q, cnt_q;
  logic             dir_q;
  logic [CNT_W:0]   err_raw, err;
  logic [CNT_W-1:0] mag_raw, mag;
  logic             db_hit;

  // Error magnitude is taken directly from the operands so no sign-extended bit goes unused.
  always_comb begin
    err_raw = {1'b0, target_q} - {1'b0, ones_q};
    mag_raw = err_raw[CNT_W] ? (ones_q - target_q) : (target_q - ones_q);
    db_hit  = DB_EN && (mag_raw <= DB);
    err     = db_hit ? '0 : err_raw;
    mag     = db_hit ? '0 : mag_raw;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fd_prop   = 1'b0;
    bk_prop   = 1'b0;
    bout      = 1'b0;
    busy_out  = 1'b1;
    done_out  = 1'b0;
    unique case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (start_in) state_nxt = FWD;
      end
      FWD: begin
        fd_prop = 1'b1;
        if (cnt_q == ONE) state_nxt = CMP;
      end
      CMP: state_nxt = (mag == '0) ? DONE : BWD;
      BWD: begin
        bk_prop = 1'b1;
        bout    = dir_q;
        if (cnt_q == ONE) state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One down-counter serves both the forward window and the backward pulse train.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      target_q  <= '0;
      ones_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      count_out <= '0;
      error_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_in) begin
          target_q <= (target_in > WIN) ? WIN : target_in;
          ones_q   <= '0;
          cnt_q    <= WIN;
        end
        FWD: begin
          ones_q <= ones_q + {{(CNT_W-1){1'b0}}, fin};
          cnt_q  <= cnt_q - ONE;
        end
        CMP: begin
          count_out <= ones_q;
          error_out <= err;
          cnt_q     <= mag;
          dir_q     <= ~err[CNT_W];
        end
        BWD:  cnt_q <= cnt_q - ONE;
        default: ;
      endcase
    end
  end

endmodule
